tile_pixel_walker: RTL

TILE_PIXEL_WALKER -- requirements
Module: tile_pixel_walker

---
 rtl/tilemap_pkg.sv | 19 +
 rtl/pixel_index.sv | 45 ++++
 rtl/tile_pixel_walker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tilemap_pkg.sv
// ----------------------------------------------------------------------------
// tilemap_pkg
//   Shared types for the tile pixel walker.
//   walk_mode_e  : pixel ordering inside a tile (row-major / column-major)
//   walk_state_e : walker control states
// ----------------------------------------------------------------------------
package tilemap_pkg;

    typedef enum logic {
        LINEAR = 1'b0,
        COLMAJ = 1'b1
    } walk_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } walk_state_e;

endpackage : tilemap_pkg

// File: rtl/pixel_index.sv
// ----------------------------------------------------------------------------
// pixel_index
//   Combinational mapping of a (row, col) pair inside a tile to a linear pixel
//   index, with optional mirroring on either axis.
//
//   Ports
//     row     in  TILE_H_LOG2   row offset within the tile
//     col     in  TILE_W_LOG2   column offset within the tile
//     flip_x  in  1             mirror the column (c = W-1-col)
//     flip_y  in  1             mirror the row    (r = H-1-row)
//     mode    in  1             0 = LINEAR (r*W+c), 1 = COLMAJ (c*H+r)
//     pix_num out W_LOG2+H_LOG2 resulting pixel index
// ----------------------------------------------------------------------------
module pixel_index
    import tilemap_pkg::*;
#(
    parameter int TILE_W_LOG2 = 3,
    parameter int TILE_H_LOG2 = 3
) (
    input  logic [TILE_H_LOG2-1:0]             row,
    input  logic [TILE_W_LOG2-1:0]             col,
    input  logic                               flip_x,
    input  logic                               flip_y,
    input  logic                               mode,
    output logic [TILE_W_LOG2+TILE_H_LOG2-1:0] pix_num
);

    logic [TILE_H_LOG2-1:0] r;
    logic [TILE_W_LOG2-1:0] c;

    // Tile dimensions are powers of two, so (N-1-x) is simply the bitwise
    // complement of x, and r*W+c / c*H+r are exact bit concatenations that
    // always fit in the full-width result.
    always_comb begin
        r       = flip_y ? ~row : row;
        c       = flip_x ? ~col : col;
        pix_num = {r, c};
        case (walk_mode_e'(mode))
            LINEAR:  pix_num = {r, c};
            COLMAJ:  pix_num = {c, r};
            default: pix_num = {r, c};
        endcase
    end

endmodule : pixel_index

// File: rtl/tile_pixel_walker.sv
// ----------------------------------------------------------------------------
// tile_pixel_walker
//   Accepts a run request (row, start column, length, flips, mode) and emits
//   one pixel index per accepted beat, walking the column by +1 modulo the
//   tile width.  All pixel outputs come straight from flops.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a request; req_ready=1, pix_valid=0
//   ST_RUN  | presenting beats; pix_valid=1, leaves on the pix_last beat
//
//   Ports
//     clk           in   clock, rising edge
//     rst_l         in   asynchronous active-low reset
//     req_valid     in   run request present
//     req_ready     out  request accepted (high only in ST_IDLE)
//     req_row       in   row offset within the tile
//     req_col       in   starting column offset
//     req_len       in   run length in pixels (0 = accept and drop)
//     req_flip_x    in   mirror the column
//     req_flip_y    in   mirror the row
//     req_mode      in   0 = LINEAR, 1 = COLMAJ
//     pix_valid     out  pix_num valid
//     pix_ready     in   consumer accepts the beat
//     pix_num       out  pixel index within the tile
//     pix_last      out  final beat of the run
//     pix_tile_adv  out  column of this beat wrapped from W-1 to 0
// ----------------------------------------------------------------------------
module tile_pixel_walker
    import tilemap_pkg::*;
#(
    parameter int TILE_W_LOG2 = 3,
    parameter int TILE_H_LOG2 = 3,
    parameter int LEN_W       = 6
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [TILE_H_LOG2-1:0]             req_row,
    input  logic [TILE_W_LOG2-1:0]             req_col,
    input  logic [LEN_W-1:0]                   req_len,
    input  logic                               req_flip_x,
    input  logic                               req_flip_y,
    input  logic                               req_mode,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [TILE_W_LOG2+TILE_H_LOG2-1:0] pix_num,
    output logic                               pix_last,
    output logic                               pix_tile_adv
);

    localparam int NUM_W = TILE_W_LOG2 + TILE_H_LOG2;
    localparam logic [LEN_W-1:0]       LEN_ONE = LEN_W'(1);
    localparam logic [TILE_W_LOG2-1:0] COL_ONE = TILE_W_LOG2'(1);

    walk_state_e state_q;
    walk_state_e state_d;

    logic [TILE_H_LOG2-1:0] row_q;
    logic [TILE_W_LOG2-1:0] col_q;
    logic [LEN_W-1:0]       left_q;     // beats still to come after the current one
    logic                   flip_x_q;
    logic                   flip_y_q;
    logic                   mode_q;

    logic [NUM_W-1:0]       num_q;
    logic                   last_q;
    logic                   adv_q;

    logic                   accept;
    logic                   beat;
    logic                   done;

    logic [TILE_W_LOG2-1:0] col_next;
    logic [TILE_H_LOG2-1:0] idx_row;
    logic [TILE_W_LOG2-1:0] idx_col;
    logic                   idx_flip_x;
    logic                   idx_flip_y;
    logic                   idx_mode;
    logic [NUM_W-1:0]       idx_num;

    assign accept   = (state_q == ST_IDLE) && req_valid && (req_len != '0);
    assign beat     = (state_q == ST_RUN) && pix_ready;
    assign done     = beat && last_q;
    assign col_next = col_q + COL_ONE;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (done)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One mapper serves both cases: in idle it maps the incoming request
    // (first beat), while running it maps the next column of the latched run.
    always_comb begin
        idx_row    = row_q;
        idx_col    = col_next;
        idx_flip_x = flip_x_q;
        idx_flip_y = flip_y_q;
        idx_mode   = mode_q;
        if (state_q == ST_IDLE) begin
            idx_row    = req_row;
            idx_col    = req_col;
            idx_flip_x = req_flip_x;
            idx_flip_y = req_flip_y;
            idx_mode   = req_mode;
        end
    end

    pixel_index #(
        .TILE_W_LOG2 (TILE_W_LOG2),
        .TILE_H_LOG2 (TILE_H_LOG2)
    ) u_pixel_index (
        .row     (idx_row),
        .col     (idx_col),
        .flip_x  (idx_flip_x),
        .flip_y  (idx_flip_y),
        .mode    (idx_mode),
        .pix_num (idx_num)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            row_q    <= '0;
            col_q    <= '0;
            left_q   <= '0;
            flip_x_q <= 1'b0;
            flip_y_q <= 1'b0;
            mode_q   <= 1'b0;
            num_q    <= '0;
            last_q   <= 1'b0;
            adv_q    <= 1'b0;
        end else if (accept) begin
            row_q    <= req_row;
            col_q    <= req_col;
            left_q   <= req_len - LEN_ONE;
            flip_x_q <= req_flip_x;
            flip_y_q <= req_flip_y;
            mode_q   <= req_mode;
            num_q    <= idx_num;
            last_q   <= (req_len == LEN_ONE);
            adv_q    <= 1'b0;
        end else if (beat) begin
            if (last_q) begin
                // Run complete: park the pixel outputs at zero while idle.
                num_q  <= '0;
                last_q <= 1'b0;
                adv_q  <= 1'b0;
            end else begin
                col_q  <= col_next;
                left_q <= left_q - LEN_ONE;
                num_q  <= idx_num;
                last_q <= (left_q == LEN_ONE);
                adv_q  <= (col_next == '0);
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign pix_valid    = (state_q == ST_RUN);
    assign pix_num      = num_q;
    assign pix_last     = last_q;
    assign pix_tile_adv = adv_q;

endmodule : tile_pixel_walker
